mem_arbiter: RTL

Three-port arbiter and sequencer that shares the single physical DDR2 memory controller port between the debug interface, instruction fetch and the pipeline data port. It sits between the requesters and `physical_ram`, replacing the split instruction/data memory paths with one unified external memory bus. It serialises one transaction at a time, drives the controller's single-cycle strobes and routes completion and read data back to the owning port. A timeout watchdog guarantees forward progress.

---
 rtl/raisin64_mem_pkg.sv | 39 +++
 rtl/mem_rr_pick.sv | 40 ++++
 rtl/mem_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/raisin64_mem_pkg.sv
// Shared definitions for the unified external memory path: FSM encoding,
// port indices, access width codes and watchdog default.
package raisin64_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mem_state_t;

    localparam logic [1:0] PORT_DBG  = 2'd0;
    localparam logic [1:0] PORT_IF   = 2'd1;
    localparam logic [1:0] PORT_DATA = 2'd2;
    localparam logic [1:0] PORT_NONE = 2'd3;

    localparam logic [1:0] WIDTH_BYTE  = 2'd0;
    localparam logic [1:0] WIDTH_HALF  = 2'd1;
    localparam logic [1:0] WIDTH_WORD  = 2'd2;
    localparam logic [1:0] WIDTH_DWORD = 2'd3;

    localparam int DEFAULT_TIMEOUT = 1024;

    // Round-robin memory: which of the two non-debug ports was served last.
    localparam logic RR_LAST_IF   = 1'b0;
    localparam logic RR_LAST_DATA = 1'b1;

    function automatic logic [2:0] port_onehot(input logic [1:0] port);
        logic [2:0] oh;
        case (port)
            PORT_DBG:  oh = 3'b001;
            PORT_IF:   oh = 3'b010;
            PORT_DATA: oh = 3'b100;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational winner selection: debug port first, then round-robin
// between instruction fetch and data, the latter two masked by dbg_halt.
module mem_rr_pick
    import raisin64_mem_pkg::*;
(
    input  logic       p0_req,
    input  logic       p1_req,
    input  logic       p2_req,
    input  logic       dbg_halt,
    input  logic       rr_last,
    output logic [1:0] win,
    output logic       win_valid
);

    // Priority then round-robin choice
    always_comb begin
        win       = PORT_NONE;
        win_valid = 1'b0;
        if (p0_req) begin
            win       = PORT_DBG;
            win_valid = 1'b1;
        end else if (!dbg_halt) begin
            if (p1_req && p2_req) begin
                win       = (rr_last == RR_LAST_DATA) ? PORT_IF : PORT_DATA;
                win_valid = 1'b1;
            end else if (p1_req) begin
                win       = PORT_IF;
                win_valid = 1'b1;
            end else if (p2_req) begin
                win       = PORT_DATA;
                win_valid = 1'b1;
            end else begin
                win_valid = 1'b0;
            end
        end else begin
            win_valid = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises debug, ifetch and data requests onto the single memory
// controller port, with a watchdog that aborts stalled transactions.
module mem_arbiter
    import raisin64_mem_pkg::*;
#(
    parameter int ADDR_W  = 27,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dbg_halt,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [63:0]       p0_addr,
    input  logic [1:0]        p0_width,
    input  logic [63:0]       p0_wdata,
    output logic              p0_done,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [63:0]       p1_addr,
    input  logic [1:0]        p1_width,
    input  logic [63:0]       p1_wdata,
    output logic              p1_done,
    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [63:0]       p2_addr,
    input  logic [1:0]        p2_width,
    input  logic [63:0]       p2_wdata,
    output logic              p2_done,
    output logic [63:0]       rdata,
    output logic              err,
    output logic              busy,
    output logic [1:0]        grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_width,
    output logic [63:0]       mem_wdata,
    output logic              mem_rstrobe,
    output logic              mem_wstrobe,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_complete
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        width_q, width_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rstrobe_q, rstrobe_d;
    logic              wstrobe_q, wstrobe_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        done_q, done_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              rr_last_q, rr_last_d;

    logic [1:0]        win_s;
    logic              win_valid_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [1:0]        sel_width_s;
    logic [63:0]       sel_wdata_s;
    logic              unused_ok_s;

    // Address bits above the controller width and the ifetch write flag are dropped.
    assign unused_ok_s = ^{p1_we, p0_addr[63:ADDR_W], p1_addr[63:ADDR_W], p2_addr[63:ADDR_W]};

    mem_rr_pick u_pick (
        .p0_req    (p0_req),
        .p1_req    (p1_req),
        .p2_req    (p2_req),
        .dbg_halt  (dbg_halt),
        .rr_last   (rr_last_q),
        .win       (win_s),
        .win_valid (win_valid_s)
    );

    // Request field mux for the current winner
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_width_s = 2'd0;
        sel_wdata_s = 64'd0;
        case (win_s)
            PORT_DBG: begin
                sel_we_s    = p0_we;
                sel_addr_s  = p0_addr[ADDR_W-1:0];
                sel_width_s = p0_width;
                sel_wdata_s = p0_wdata;
            end
            PORT_IF: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = p1_addr[ADDR_W-1:0];
                sel_width_s = p1_width;
                sel_wdata_s = p1_wdata;
            end
            PORT_DATA: begin
                sel_we_s    = p2_we;
                sel_addr_s  = p2_addr[ADDR_W-1:0];
                sel_width_s = p2_width;
                sel_wdata_s = p2_wdata;
            end
            default: begin
                sel_we_s = 1'b0;
            end
        endcase
    end

    // Sequencer next-state and registered output values
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        width_d   = width_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rstrobe_d = 1'b0;
        wstrobe_d = 1'b0;
        cnt_d     = cnt_q;
        done_d    = 3'b000;
        rdata_d   = rdata_q;
        err_d     = err_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid_s) begin
                    state_d   = ST_ISSUE;
                    grant_d   = win_s;
                    addr_d    = sel_addr_s;
                    width_d   = sel_width_s;
                    wdata_d   = sel_wdata_s;
                    we_d      = sel_we_s;
                    rstrobe_d = !sel_we_s;
                    wstrobe_d = sel_we_s;
                    if (win_s == PORT_IF) begin
                        rr_last_d = RR_LAST_IF;
                    end else if (win_s == PORT_DATA) begin
                        rr_last_d = RR_LAST_DATA;
                    end else begin
                        rr_last_d = rr_last_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion beats a simultaneous watchdog expiry.
                if (mem_complete) begin
                    rdata_d = we_q ? 64'd0 : mem_rdata;
                    err_d   = 1'b0;
                    done_d  = port_onehot(grant_q);
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 64'd0;
                    err_d   = 1'b1;
                    done_d  = port_onehot(grant_q);
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                grant_d = PORT_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = PORT_NONE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= PORT_NONE;
            addr_q    <= '0;
            width_q   <= 2'd0;
            wdata_q   <= 64'd0;
            we_q      <= 1'b0;
            rstrobe_q <= 1'b0;
            wstrobe_q <= 1'b0;
            cnt_q     <= '0;
            done_q    <= 3'b000;
            rdata_q   <= 64'd0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            rr_last_q <= RR_LAST_DATA;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            width_q   <= width_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rstrobe_q <= rstrobe_d;
            wstrobe_q <= wstrobe_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign p0_done     = done_q[0];
    assign p1_done     = done_q[1];
    assign p2_done     = done_q[2];
    assign rdata       = rdata_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign grant       = grant_q;
    assign mem_addr    = addr_q;
    assign mem_width   = width_q;
    assign mem_wdata   = wdata_q;
    assign mem_rstrobe = rstrobe_q;
    assign mem_wstrobe = wstrobe_q;

endmodule
